// File: rtl/end_screen_ctrl.sv
// Game-over screen sequencer: reveal, show, blinking prompts and a single restart/credit request.
// Optional attract-mode timeout in PROMPT is enabled by defining END_SCREEN_TIMEOUT_EN.
module end_screen_ctrl #(
   parameter int unsigned REVEAL_FRAMES  = 30,
   parameter int unsigned PROMPT_FRAMES  = 60,
   parameter int unsigned BLINK_FRAMES   = 16,
   parameter int unsigned TIMEOUT_FRAMES = 600,
   parameter int unsigned CNT_W          = 10
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_of_frame_i,
   input  logic       game_ended_i,
   input  logic       new_high_score_i,
   input  logic       key_start_i,
   input  logic       key_credit_i,
   output logic       end_screen_en_o,
   output logic       game_over_visible_o,
   output logic       high_score_on_o,
   output logic       prompt_on_o,
   output logic       restart_req_o,
   output logic       credit_req_o,
   output logic       attract_req_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StReveal = 2'd1,
      StShow   = 2'd2,
      StPrompt = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] RevealLast = CNT_W'(REVEAL_FRAMES - 1);
   localparam logic [CNT_W-1:0] PromptLast = CNT_W'(PROMPT_FRAMES - 1);
   localparam logic [CNT_W-1:0] BlinkLast  = CNT_W'(BLINK_FRAMES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d, blink_cnt_step;
   logic             phase_q, phase_d, phase_step;
   logic             hs_q, hs_d;
   logic             valid_q, game_ended_q, key_start_q, key_credit_q;
   logic             ge_rise, ks_rise, kc_rise;
   logic             en_d, gov_d, hs_on_d, prompt_d, restart_d, credit_d, attract_d;

   // Edges are only trusted once the previous-value registers hold a post-reset sample.
   assign ge_rise = valid_q & game_ended_i & ~game_ended_q;
   assign ks_rise = valid_q & key_start_i & ~key_start_q;
   assign kc_rise = valid_q & key_credit_i & ~key_credit_q;

   assign cnt_inc        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign blink_cnt_step = (blink_cnt_q == BlinkLast) ? '0 : blink_cnt_q + 1'b1;
   assign phase_step     = (blink_cnt_q == BlinkLast) ? ~phase_q : phase_q;

`ifdef END_SCREEN_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_FRAMES - 1);
`else
   logic unused_timeout;
   assign unused_timeout = ^CNT_W'(TIMEOUT_FRAMES);
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      hs_d        = hs_q;
      restart_d   = 1'b0;
      credit_d    = 1'b0;
      attract_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (ge_rise) begin
               hs_d    = new_high_score_i;
               cnt_d   = '0;
               state_d = StReveal;
            end
         end
         StReveal: begin
            if (!game_ended_i) begin
               state_d = StIdle;
            end else if (start_of_frame_i) begin
               if (cnt_q == RevealLast) begin
                  state_d     = StShow;
                  cnt_d       = '0;
                  blink_cnt_d = '0;
                  phase_d     = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StShow: begin
            if (!game_ended_i) begin
               state_d = StIdle;
            end else if (start_of_frame_i) begin
               blink_cnt_d = blink_cnt_step;
               phase_d     = phase_step;
               if (cnt_q == PromptLast) begin
                  state_d = StPrompt;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StPrompt: begin
            if (!game_ended_i) begin
               state_d = StIdle;
            end else if (ks_rise) begin
               restart_d = 1'b1;
               state_d   = StIdle;
            end else begin
               if (start_of_frame_i) begin
                  blink_cnt_d = blink_cnt_step;
                  phase_d     = phase_step;
               end
               if (kc_rise) begin
                  credit_d = 1'b1;
                  cnt_d    = '0;
               end
`ifdef END_SCREEN_TIMEOUT_EN
               else if (start_of_frame_i) begin
                  if (cnt_q == TimeoutLast) begin
                     attract_d = 1'b1;
                     state_d   = StIdle;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      en_d     = (state_d != StIdle);
      gov_d    = (state_d == StShow) || (state_d == StPrompt);
      hs_on_d  = gov_d & hs_d & phase_d;
      prompt_d = (state_d == StPrompt) & phase_d;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q             <= StIdle;
         cnt_q               <= '0;
         blink_cnt_q         <= '0;
         phase_q             <= 1'b0;
         hs_q                <= 1'b0;
         valid_q             <= 1'b0;
         game_ended_q        <= 1'b0;
         key_start_q         <= 1'b0;
         key_credit_q        <= 1'b0;
         end_screen_en_o     <= 1'b0;
         game_over_visible_o <= 1'b0;
         high_score_on_o     <= 1'b0;
         prompt_on_o         <= 1'b0;
         restart_req_o       <= 1'b0;
         credit_req_o        <= 1'b0;
         attract_req_o       <= 1'b0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         blink_cnt_q         <= blink_cnt_d;
         phase_q             <= phase_d;
         hs_q                <= hs_d;
         valid_q             <= 1'b1;
         game_ended_q        <= game_ended_i;
         key_start_q         <= key_start_i;
         key_credit_q        <= key_credit_i;
         end_screen_en_o     <= en_d;
         game_over_visible_o <= gov_d;
         high_score_on_o     <= hs_on_d;
         prompt_on_o         <= prompt_d;
         restart_req_o       <= restart_d;
         credit_req_o        <= credit_d;
         attract_req_o       <= attract_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Bench for end_screen_ctrl: directed flow plus random stimulus against a frame-count reference model.
module tb_end_screen_ctrl;

   localparam int unsigned Reveal  = 3;
   localparam int unsigned Prompt  = 4;
   localparam int unsigned Blink   = 2;
   localparam int unsigned Timeout = 5;
`ifdef END_SCREEN_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sof = 1'b0, ge = 1'b0, nhs = 1'b0, ks = 1'b0, kc = 1'b0;
   logic       en, gov, hso, pon, rr, cr, ar;
   logic [1:0] st;
   logic [8:0] dut_vec;

   int compared = 0;
   int mismatched = 0;

   // Reference model: state as a number, frames counted since each milestone.
   int m_state, m_cnt, m_fs;
   bit m_hs, m_valid, m_pge, m_pks, m_pkc, m_rr, m_cr, m_ar;

   end_screen_ctrl #(
      .REVEAL_FRAMES (Reveal),
      .PROMPT_FRAMES (Prompt),
      .BLINK_FRAMES  (Blink),
      .TIMEOUT_FRAMES(Timeout),
      .CNT_W         (10)
   ) dut (
      .clk_i              (clk),
      .reset_i            (reset),
      .start_of_frame_i   (sof),
      .game_ended_i       (ge),
      .new_high_score_i   (nhs),
      .key_start_i        (ks),
      .key_credit_i       (kc),
      .end_screen_en_o    (en),
      .game_over_visible_o(gov),
      .high_score_on_o    (hso),
      .prompt_on_o        (pon),
      .restart_req_o      (rr),
      .credit_req_o       (cr),
      .attract_req_o      (ar),
      .state_o            (st)
   );

   assign dut_vec = {st, en, gov, hso, pon, rr, cr, ar};

   always #5 clk = ~clk;

   function automatic logic [8:0] exp_vec();
      logic [1:0] s;
      bit ph;
      s  = 2'(m_state);
      ph = ((m_fs / Blink) % 2) == 0;
      return {s, m_state != 0, m_state >= 2, m_hs && m_state >= 2 && ph,
              m_state == 3 && ph, m_rr, m_cr, m_ar};
   endfunction

   task automatic check(input string tag, input logic [8:0] expv);
      compared++;
      assert (dut_vec === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %b required %b (st,en,gov,hs,prompt,rr,cr,ar)", tag, dut_vec,
                expv);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_fs = 0; m_hs = 0; m_valid = 0;
      m_pge = 0; m_pks = 0; m_pkc = 0; m_rr = 0; m_cr = 0; m_ar = 0;
   endtask

   task automatic model_step();
      bit ge_r, ks_r, kc_r;
      ge_r = m_valid && ge && !m_pge;
      ks_r = m_valid && ks && !m_pks;
      kc_r = m_valid && kc && !m_pkc;
      m_rr = 0; m_cr = 0; m_ar = 0;
      case (m_state)
         0: if (ge_r) begin m_hs = nhs; m_cnt = 0; m_state = 1; end
         1: if (!ge) m_state = 0;
            else if (sof) begin
               m_cnt++;
               if (m_cnt == Reveal) begin m_state = 2; m_cnt = 0; m_fs = 0; end
            end
         2: if (!ge) m_state = 0;
            else if (sof) begin
               m_cnt++; m_fs++;
               if (m_cnt == Prompt) begin m_state = 3; m_cnt = 0; end
            end
         default: if (!ge) m_state = 0;
            else if (ks_r) begin m_rr = 1; m_state = 0; end
            else begin
               if (sof) m_fs++;
               if (kc_r) begin m_cr = 1; m_cnt = 0; end
               else if (sof) begin
                  m_cnt++;
                  if (TimeoutEn && m_cnt == Timeout) begin m_ar = 1; m_state = 0; end
               end
            end
      endcase
      m_pge = ge; m_pks = ks; m_pkc = kc; m_valid = 1;
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check(tag, exp_vec());
   endtask

   task automatic frames(input int k, input string tag);
      for (int i = 0; i < k; i++) begin
         sof = 1'b0;
         repeat ($urandom_range(0, 2)) cyc(tag);
         sof = 1'b1;
         cyc(tag);
         sof = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      ge = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("reset_state", 9'b0);

      // gameEnded already high at reset release: no edge, stay idle.
      @(negedge clk) reset = 1'b0;
      repeat (4) cyc("ge_high_at_release");

      // Basic flow with high score, start key held from REVEAL onward.
      ge = 1'b0; cyc("ge_low");
      ge = 1'b1; nhs = 1'b1; cyc("ge_rise");
      ks = 1'b1;
      frames(Reveal, "reveal");
      frames(Prompt, "show");
      frames(3, "prompt_held_key");
      ks = 1'b0; cyc("key_release");
      ks = 1'b1; cyc("restart_pulse");
      cyc("after_restart");
      ks = 1'b0;

      // No high score, credit restarts timeout.
      ge = 1'b0; cyc("ge_low2");
      ge = 1'b1; nhs = 1'b0; cyc("ge_rise2");
      frames(Reveal + Prompt, "to_prompt2");
      frames(2, "prompt2");
      kc = 1'b1; cyc("credit_pulse");
      kc = 1'b0; cyc("credit_after");
      frames(3, "post_credit");
      frames(3, "timeout_window");
      frames(22, "long_wait");

      // Simultaneous start and credit edges.
      ge = 1'b0; cyc("ge_low3");
      ge = 1'b1; nhs = 1'($urandom_range(0, 1)); cyc("ge_rise3");
      frames(Reveal + Prompt, "to_prompt3");
      ks = 1'b1; kc = 1'b1; cyc("both_keys");
      cyc("both_after");
      ks = 1'b0; kc = 1'b0;

      // Abort during SHOW.
      ge = 1'b0; cyc("ge_low4");
      ge = 1'b1; nhs = 1'b1; cyc("ge_rise4");
      frames(Reveal + 1, "into_show");
      ge = 1'b0; cyc("abort_show");
      cyc("abort_after");

      // Asynchronous reset in PROMPT together with a key edge.
      ge = 1'b1; cyc("ge_rise5");
      frames(Reveal + Prompt, "to_prompt5");
      ks = 1'b1;
      #2 reset = 1'b1;
      #1 check("reset_async", 9'b0);
      @(posedge clk);
      #1 check("reset_held", 9'b0);
      @(negedge clk) reset = 1'b0;
      model_reset();
      repeat (3) cyc("after_reset");
      ks = 1'b0;

      // Random stimulus.
      for (int i = 0; i < 600; i++) begin
         sof = ($urandom_range(0, 2) == 0);
         if (ge) ge = ($urandom_range(0, 40) != 0);
         else ge = ($urandom_range(0, 2) == 0);
         nhs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 12) == 0) ks = ~ks;
         if ($urandom_range(0, 8) == 0) kc = ~kc;
         cyc("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/end_screen_ctrl.md
# end_screen_ctrl

Frame-paced sequencer for the game-over screen. It detects the end of a game, reveals the game-over banner, blinks the high-score indication, enables the start/credit key prompts after a lock-out, and turns the player's key press into a single restart or credit request toward the game controller. Its outputs drive the enable and standby inputs of the end-screen bitmap objects and the top-level game state logic.

## Interface
Parameters:
- REVEAL_FRAMES, 30: frames from game end until the game-over banner is shown.
- PROMPT_FRAMES, 60: frames the banner is shown before key prompts appear; keys are ignored during this time.
- BLINK_FRAMES, 16: half-period of every blink, in frames.
- TIMEOUT_FRAMES, 600: frames in PROMPT with no key press before an attract request (macro-gated).
- CNT_W, 10: frame counter width; every *_FRAMES value must be ≥1 and ≤2^CNT_W−1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- gameEnded  in  1  level; high while the game is over.
- newHighScore  in  1  level; sampled at game end.
- keyStart  in  1  start key level, already synchronised.
- keyCredit  in  1  credit key level, already synchronised.
- endScreenEn  out  1  end screen is active; gates endScreenDR at the top level.
- gameOverVisible  out  1  game-over banner shown.
- highScoreOn  out  1  high-score banner phase; blinks.
- promptOn  out  1  start/credit prompts shown; blinks.
- restartReq  out  1  one-cycle pulse: start the new game.
- creditReq  out  1  one-cycle pulse: add a credit.
- attractReq  out  1  one-cycle pulse: leave to attract mode.
- state  out  2  current state encoding, for debug.

## Operation
- States:
  - IDLE = 0
  - REVEAL = 1
  - SHOW = 2
  - PROMPT = 3
- All outputs are registered. After reset: state = IDLE, every output = 0, the frame counter and blink counter = 0, and the high-score latch = 0.
- **IDLE**
  - On a rising edge of gameEnded (registered previous value low, current value high): latch newHighScore, clear the frame counter, go to REVAL... go to REVEAL.
  - If gameEnded is already high when reset is released, no rising edge is seen and the block stays in IDLE.
- **REVEAL**
  - endScreenEn = 1.
  - The frame counter increments on each startOfFrame.
  - On the startOfFrame at which the count reaches REVEAL_FRAMES−1: go to SHOW and clear the counter.
- **SHOW**
  - gameOverVisible = 1.
  - The count target is PROMPT_FRAMES−1; when it is reached, go to PROMPT and clear the counter.
- **PROMPT**
  - gameOverVisible = 1.
  - promptOn follows the blink phase.
  - Key rising edges are acted on only in this state. Edges that occurred earlier are discarded, so a key held down through SHOW produces no request.
  - keyStart edge: restartReq pulses and the block goes to IDLE.
  - keyCredit edge: creditReq pulses and the block stays in PROMPT with the timeout counter cleared.
  - Both edges in the same cycle: restartReq only (start wins) and the block goes to IDLE.
- **Blink**
  - The blink counter counts startOfFrame pulses in SHOW and PROMPT. The phase toggles every BLINK_FRAMES frames.
  - The phase is 1 on entry to SHOW.
  - highScoreOn = latched high-score flag AND phase, in SHOW and PROMPT.
- **Abort**
  - gameEnded low in any non-IDLE state: go to IDLE on the next cycle. All visibility outputs drop, and no pulse is generated.
  - If a key edge arrives in the same cycle as the abort, the abort wins.
- Counters saturate and never wrap. The counter compare happens only on startOfFrame cycles.

## Timing
- Input to output latency is 1 clk: a state change is visible on the clock edge after the qualifying input.
- restartReq, creditReq and attractReq are exactly 1 clk wide.
- There is at most one request pulse per cycle.
- Key edge detection uses a registered previous value. Its first valid sample is the cycle after reset is released.
- Timing from the gameEnded rise: gameOverVisible rises REVEAL_FRAMES startOfFrame pulses after the cycle of the gameEnded rise, plus 1 clk.
- Reset asserted mid-operation clears everything immediately and asynchronously. No pulses are emitted during reset or on its release.

## Configuration
- Macro END_SCREEN_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in PROMPT.
  - On the startOfFrame at which it reaches TIMEOUT_FRAMES−1 with no key edge: attractReq pulses and the block goes to IDLE.
  - A key edge on that same cycle takes priority over the timeout.
- Undefined:
  - PROMPT waits indefinitely.
  - attractReq is tied to 0.
  - TIMEOUT_FRAMES is unused.

## Test plan
All scenarios use REVEAL_FRAMES=3, PROMPT_FRAMES=4, BLINK_FRAMES=2, TIMEOUT_FRAMES=5.
- Basic flow: reset, then raise gameEnded → state goes 1; after 3 frames state = 2 and gameOverVisible = 1; after 4 more frames state = 3 and promptOn = 1, toggling every 2 frames.
- High score: newHighScore = 1 at game end → highScoreOn toggles with period 4 frames in SHOW and PROMPT. With newHighScore = 0, highScoreOn stays 0.
- Key lock-out and priority:
  - keyStart held high from REVEAL onward → no restartReq.
  - In PROMPT, release keyStart and press it again → a single 1-clk restartReq, then state = 0.
  - keyStart and keyCredit rising together → restartReq only.
- Credit: keyCredit pulse in PROMPT → creditReq for 1 clk, state remains 3, and the timeout restarts.
- Timeout:
  - With END_SCREEN_TIMEOUT_EN: 5 idle frames in PROMPT → attractReq for 1 clk, state = 0.
  - Without it: the block stays in state 3 for more than 20 frames and attractReq stays 0.
- Abort and reset:
  - Drop gameEnded during SHOW → state = 0 the next clk, all outputs 0.
  - Assert reset in PROMPT while a key edge arrives → outputs 0 immediately, no pulse.
